lif_neuron_integrator: RTL and testbench

Post-synaptic leaky integrate-and-fire neuron that consumes the 16 stored synaptic weights owned by the STDP timer/weight unit.
- Once per time step it applies leak, sequentially reads the weights, and accumulates those whose pre-synaptic spike bit is set.
- It compares the membrane potential against threshold and emits the post-synaptic spike.
- That spike feeds the post-synaptic serial input of the STDP timing shift register.

---
 rtl/lif_neuron_integrator.sv | 120 ++++++++++++
 tb/tb_lif_neuron_integrator.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_integrator.sv
// lif_neuron_integrator: leaky integrate-and-fire neuron over NUM_SYN stored weights; define LIF_ADAPTIVE_THRESH_EN for an adaptive threshold
module lif_neuron_integrator #(
  parameter int NUM_SYN = 16,
  parameter int W_WIDTH = 16,
  parameter int V_WIDTH = 24,
  parameter logic [V_WIDTH-1:0] THRESHOLD = 24'h010000,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT_STEPS = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       step_start,
  input  logic [NUM_SYN-1:0]         pre_spikes,
  output logic [$clog2(NUM_SYN)-1:0] weight_sel,
  input  logic [W_WIDTH-1:0]         weight_data,
  output logic                       post_spike,
  output logic                       step_done,
  output logic                       busy,
  output logic [V_WIDTH-1:0]         membrane
);
  localparam int IW = $clog2(NUM_SYN);
  localparam int CW = $clog2(NUM_SYN + 1);
  localparam int RW = $clog2(REFRACT_STEPS + 1);
  typedef enum logic [2:0] {IDLE, LEAK, ACCUM, FIRE, REFRACT} state_t;
  state_t               state_q, state_d;
  logic [NUM_SYN-1:0]   spikes_q, spikes_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic [V_WIDTH-1:0]   membrane_q, membrane_d;
  logic [RW-1:0]        refract_q, refract_d;
  logic                 post_q, post_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [V_WIDTH-1:0]   thr;
  logic [NUM_SYN:0]     spk_ext;
  logic                 fire;
  // bit k of spk_ext is the spike belonging to the weight that arrives on ACCUM cycle k
  assign spk_ext = {spikes_q, 1'b0};
  assign fire = membrane_q >= thr;
`ifdef LIF_ADAPTIVE_THRESH_EN
  localparam logic [V_WIDTH-1:0] THR_INC = THRESHOLD >> 2;
  localparam logic [V_WIDTH-1:0] THR_DEC = THRESHOLD >> 4;
  localparam logic [V_WIDTH-1:0] THR_MAX = THRESHOLD << 1;
  logic [V_WIDTH-1:0] thr_q, thr_d;
  assign thr = thr_q;
  // raise the threshold on a fire, relax it toward THRESHOLD on every quiet step
  always_comb begin
    thr_d = thr_q;
    if (state_q == FIRE && fire)
      thr_d = thr_q > THR_MAX - THR_INC ? THR_MAX : thr_q + THR_INC;
    else if (state_q == FIRE || state_q == REFRACT)
      thr_d = thr_q > THRESHOLD + THR_DEC ? thr_q - THR_DEC : THRESHOLD;
  end
  // adaptive threshold register
  always_ff @(posedge clock) thr_q <= reset ? THRESHOLD : thr_d;
`else
  assign thr = THRESHOLD;
`endif
  // step sequencer: leak, issue weight reads with one-cycle latency, accumulate, compare
  always_comb begin
    state_d    = state_q;
    spikes_d   = spikes_q;
    cnt_d      = cnt_q;
    sel_d      = '0;
    membrane_d = membrane_q;
    refract_d  = refract_q;
    post_d     = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q & ~done_q;
    case (state_q)
      IDLE: if (step_start) begin
        spikes_d = pre_spikes;
        busy_d   = 1'b1;
        state_d  = LEAK;
      end
      LEAK: begin
        membrane_d = membrane_q - (membrane_q >> LEAK_SHIFT);
        cnt_d      = '0;
        state_d    = refract_q != '0 ? REFRACT : ACCUM;
      end
      ACCUM: begin
        cnt_d      = cnt_q + 1'b1;
        sel_d      = cnt_q < CW'(NUM_SYN - 1) ? IW'(cnt_q + 1'b1) : '0;
        membrane_d = spk_ext[cnt_q] ? membrane_q + V_WIDTH'(weight_data) : membrane_q;
        state_d    = cnt_q == CW'(NUM_SYN) ? FIRE : ACCUM;
      end
      FIRE: begin
        post_d     = fire;
        membrane_d = fire ? '0 : membrane_q;
        refract_d  = fire ? RW'(REFRACT_STEPS) : refract_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      REFRACT: begin
        refract_d  = refract_q - 1'b1;
        membrane_d = '0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any step in progress
  always_ff @(posedge clock) begin
    state_q    <= reset ? IDLE : state_d;
    spikes_q   <= reset ? '0 : spikes_d;
    cnt_q      <= reset ? '0 : cnt_d;
    sel_q      <= reset ? '0 : sel_d;
    membrane_q <= reset ? '0 : membrane_d;
    refract_q  <= reset ? '0 : refract_d;
    post_q     <= reset ? 1'b0 : post_d;
    done_q     <= reset ? 1'b0 : done_d;
    busy_q     <= reset ? 1'b0 : busy_d;
  end
  assign weight_sel = sel_q;
  assign post_spike = post_q;
  assign step_done  = done_q;
  assign busy       = busy_q;
  assign membrane   = membrane_q;
endmodule

// File: tb/tb_lif_neuron_integrator.sv
// tb_lif_neuron_integrator: randomized and directed checks against a step-level neuron model
module tb_lif_neuron_integrator;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        step_start = 1'b0;
  logic [15:0] pre_spikes = '0;
  logic [3:0]  weight_sel;
  logic [15:0] weight_data = '0;
  logic        post_spike, step_done, busy;
  logic [23:0] membrane;
  logic [15:0] wmem [16];
  int          checks = 0;
  int          failures = 0;
  int unsigned m_v = 0;
  int          m_ref = 0;
  bit          pre_driven = 0;

  lif_neuron_integrator dut (
    .clock(clk), .reset(rst), .step_start(step_start), .pre_spikes(pre_spikes),
    .weight_sel(weight_sel), .weight_data(weight_data), .post_spike(post_spike),
    .step_done(step_done), .busy(busy), .membrane(membrane)
  );

  always #5 clk = ~clk;
  always @(posedge clk) weight_data <= wmem[weight_sel];

  function automatic int exp_sel(int n);
    return (n >= 1 && n <= 16) ? n - 1 : 0;
  endfunction

  task automatic set_weights(input int mode);
    for (int i = 0; i < 16; i++)
      wmem[i] = mode == 0 ? 16'h4000 : mode == 1 ? 16'(16'h0100 * (i + 1)) : 16'($urandom_range(0, 16'h1800));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    step_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_v = 0;
    m_ref = 0;
  endtask

  task automatic run_step(input logic [15:0] s, input bit chain, input logic [15:0] s2, input bit poke);
    int unsigned pre_v;
    bit refr, fire;
    int n, exp_n, bad_sel, bad_post;
    if (!pre_driven) begin
      @(negedge clk);
      step_start = 1'b1;
      pre_spikes = s;
    end
    pre_driven = 0;
    @(negedge clk);
    step_start = 1'b0;
    pre_spikes = 16'($urandom);
    m_v = m_v - (m_v >> 3);
    refr = m_ref > 0;
    fire = 0;
    pre_v = 0;
    if (refr) begin
      m_ref--;
      m_v = 0;
    end else begin
      for (int i = 0; i < 16; i++) if (s[i]) m_v += wmem[i];
      pre_v = m_v;
      fire = m_v >= 32'h10000;
      if (fire) begin
        m_v = 0;
        m_ref = 2;
      end
    end
    exp_n = refr ? 2 : 19;
    n = 0;
    bad_sel = 0;
    bad_post = 0;
    while (n < 40 && !step_done) begin
      if (post_spike) bad_post++;
      if (weight_sel !== 4'(exp_sel(n))) bad_sel++;
      if (n == 10) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_mid_step got=%b want=1", busy);
        end
      end
      if (n == 18) begin
        checks++;
        if (membrane !== 24'(pre_v)) begin
          failures++;
          $display("FAIL membrane_pre_fire got=%h want=%h", membrane, 24'(pre_v));
        end
      end
      if (poke) begin
        if (n == 5) step_start = 1'b1;
        if (n == 6) step_start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != exp_n) begin
      failures++;
      $display("FAIL step_latency got=%0d want=%0d", n, exp_n);
    end
    if (n >= 40) return;
    checks++;
    if (post_spike !== fire) begin
      failures++;
      $display("FAIL post_spike got=%b want=%b", post_spike, fire);
    end
    checks++;
    if (membrane !== 24'(m_v)) begin
      failures++;
      $display("FAIL membrane_after_step got=%h want=%h", membrane, 24'(m_v));
    end
    checks++;
    if (bad_sel != 0 || bad_post != 0 || weight_sel !== 4'd0) begin
      failures++;
      $display("FAIL sel_post_sequence got=%0d/%0d bad cycles want=0/0", bad_sel, bad_post);
    end
    if (chain) begin
      step_start = 1'b1;
      pre_spikes = s2;
      pre_driven = 1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (membrane !== 24'd0 || busy !== 1'b0 || step_done !== 1'b0 || post_spike !== 1'b0 || weight_sel !== 4'd0) begin
      failures++;
      $display("FAIL reset_state got=%h/%b/%b/%b/%h want=0/0/0/0/0", membrane, busy, step_done, post_spike, weight_sel);
    end
  endtask

  task automatic test_all_spikes();
    do_reset();
    set_weights(0);
    run_step(16'hFFFF, 0, 0, 0);
  endtask

  task automatic test_threshold_equal();
    do_reset();
    set_weights(0);
    run_step(16'h000F, 0, 0, 0);
  endtask

  task automatic test_no_fire_leak();
    do_reset();
    set_weights(0);
    run_step(16'h0007, 0, 0, 0);
    run_step(16'h0000, 0, 0, 0);
    checks++;
    if (membrane !== 24'd43008) begin
      failures++;
      $display("FAIL leak_value got=%0d want=43008", membrane);
    end
  endtask

  task automatic test_refractory();
    do_reset();
    set_weights(0);
    run_step(16'hFFFF, 0, 0, 0);
    run_step(16'hFFFF, 0, 0, 0);
    run_step(16'hFFFF, 0, 0, 0);
    run_step(16'h0007, 0, 0, 0);
  endtask

  task automatic test_weight_seq();
    do_reset();
    set_weights(1);
    run_step(16'hAAAA, 0, 0, 0);
    checks++;
    if (membrane !== 24'h004800) begin
      failures++;
      $display("FAIL weight_seq_sum got=%h want=004800", membrane);
    end
  endtask

  task automatic test_reset_mid_accum();
    int dones;
    do_reset();
    set_weights(0);
    run_step(16'h0007, 0, 0, 0);
    @(negedge clk);
    step_start = 1'b1;
    pre_spikes = 16'hFFFF;
    @(negedge clk);
    step_start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_v = 0;
    m_ref = 0;
    checks++;
    if (membrane !== 24'd0 || busy !== 1'b0 || step_done !== 1'b0 || weight_sel !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_accum got=%h/%b/%b/%h want=0/0/0/0", membrane, busy, step_done, weight_sel);
    end
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_done) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL no_done_after_reset got=%0d want=0", dones);
    end
    run_step(16'h000F, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_weights(0);
    run_step(16'h0007, 1, 16'h0001, 0);
    run_step(16'h0001, 0, 0, 0);
    checks++;
    if (membrane !== 24'd59392) begin
      failures++;
      $display("FAIL back_to_back got=%0d want=59392", membrane);
    end
  endtask

  task automatic test_busy_drop();
    int dones;
    do_reset();
    set_weights(0);
    run_step(16'h0003, 0, 0, 1);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (step_done) dones++;
    end
    checks++;
    if (dones != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_drop got=%0d/%b want=0/0", dones, busy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) set_weights(2);
      run_step(16'($urandom), 0, 0, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wmem[i] = '0;
    test_reset();
    test_all_spikes();
    test_threshold_equal();
    test_no_fire_leak();
    test_refractory();
    test_weight_seq();
    test_reset_mid_accum();
    test_back_to_back();
    test_busy_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
